// File: rtl/bram_load_sequencer_pkg.sv
// Shared state encodings, error codes and the byte-enable mask helper for
// the BRAM load sequencer.
package bram_load_pkg;

    localparam logic [4:0] S_IDLE   = 5'b00001;
    localparam logic [4:0] S_ISSUE  = 5'b00010;
    localparam logic [4:0] S_WAIT   = 5'b00100;
    localparam logic [4:0] S_NEXT   = 5'b01000;
    localparam logic [4:0] S_FINISH = 5'b10000;

    typedef enum logic [4:0] {
        ST_IDLE   = S_IDLE,
        ST_ISSUE  = S_ISSUE,
        ST_WAIT   = S_WAIT,
        ST_NEXT   = S_NEXT,
        ST_FINISH = S_FINISH
    } state_t;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_TIMEOUT = 2'b01;
    localparam logic [1:0] ERR_ABORT   = 2'b10;

    // The writer fills bit 3 first, so a partial tail word sets the top bits.
    function automatic logic [3:0] tail_mask(input logic [31:0] remaining);
        if (remaining >= 32'd4) begin
            return 4'b1111;
        end
        case (remaining[1:0])
            2'd3:    return 4'b1110;
            2'd2:    return 4'b1100;
            2'd1:    return 4'b1000;
            default: return 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/bram_load_sequencer_wait_timer.sv
// Down-counter that bounds the time spent waiting for a writer completion;
// expired is high on the last allowed cycle after a load.
module wait_timer #(
    parameter int CYCLES = 65535
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic en,
    output logic expired
);

    localparam int W = (CYCLES > 1) ? $clog2(CYCLES) : 1;

    logic [W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= W'(CYCLES - 1);
        end else if (en && (r_count != '0)) begin
            r_count <= r_count - W'(1);
        end
    end

    assign expired = (r_count == '0);

endmodule

// File: rtl/bram_load_sequencer.sv
// Splits a (base address, byte count) load command into per-word writer
// requests, one at a time, with timeout and word-boundary abort handling.
module bram_load_sequencer
    import bram_load_pkg::*;
#(
    parameter int ADDR_W         = 9,
    parameter int CNT_W          = 12,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  byte_count,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic [1:0]        err_code,
    output logic [ADDR_W:0]   words_done,
    output logic              wr_enable,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [3:0]        wr_bytes,
    input  logic              wr_complete
);

    state_t            r_state;
    logic [ADDR_W-1:0] r_cur_addr;
    logic [CNT_W-1:0]  r_remaining;
    logic              r_abort_pending;
    logic [1:0]        r_err_code;
    logic [ADDR_W:0]   r_words_done;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [3:0]        r_wr_bytes;

    logic              w_expired;
    logic [CNT_W-1:0]  w_step;

    assign w_step = (r_remaining >= CNT_W'(4)) ? CNT_W'(4) : r_remaining;

    wait_timer #(
        .CYCLES (TIMEOUT_CYCLES)
    ) u_wait_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (r_state == ST_ISSUE),
        .en      (r_state == ST_WAIT),
        .expired (w_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= ST_IDLE;
            r_cur_addr      <= '0;
            r_remaining     <= '0;
            r_abort_pending <= 1'b0;
            r_err_code      <= ERR_NONE;
            r_words_done    <= '0;
            r_wr_addr       <= '0;
            r_wr_bytes      <= 4'b0000;
        end else begin
            if (abort && (r_state inside {ST_ISSUE, ST_WAIT, ST_NEXT})) begin
                r_abort_pending <= 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_cur_addr      <= base_addr;
                        r_remaining     <= byte_count;
                        r_words_done    <= '0;
                        r_err_code      <= ERR_NONE;
                        r_abort_pending <= 1'b0;
                        if (byte_count == '0) begin
                            r_state <= ST_FINISH;
                        end else begin
                            r_state    <= ST_ISSUE;
                            r_wr_addr  <= base_addr;
                            r_wr_bytes <= tail_mask(32'(byte_count));
                        end
                    end
                end
                ST_ISSUE: r_state <= ST_WAIT;
                // Completion takes priority over a timeout in the same cycle.
                ST_WAIT: begin
                    if (wr_complete) begin
                        r_words_done <= r_words_done + {{ADDR_W{1'b0}}, 1'b1};
                        r_remaining  <= r_remaining - w_step;
                        r_cur_addr   <= r_cur_addr + ADDR_W'(1);
                        r_state      <= ST_NEXT;
                    end else if (w_expired) begin
                        r_err_code <= ERR_TIMEOUT;
                        r_state    <= ST_FINISH;
                    end
                end
                ST_NEXT: begin
                    if (r_remaining == '0) begin
                        r_err_code <= ERR_NONE;
                        r_state    <= ST_FINISH;
                    end else if (r_abort_pending) begin
                        r_err_code <= ERR_ABORT;
                        r_state    <= ST_FINISH;
                    end else begin
                        r_wr_addr  <= r_cur_addr;
                        r_wr_bytes <= tail_mask(32'(r_remaining));
                        r_state    <= ST_ISSUE;
                    end
                end
                ST_FINISH: r_state <= ST_IDLE;
                default:   r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy       = (r_state != ST_IDLE);
    assign done       = (r_state == ST_FINISH);
    assign wr_enable  = (r_state == ST_ISSUE);
    assign err_code   = r_err_code;
    assign words_done = r_words_done;
    assign wr_addr    = r_wr_addr;
    assign wr_bytes   = r_wr_bytes;

endmodule

// File: tb/tb_bram_load_sequencer.sv
// Scoreboard bench for bram_load_sequencer: directed commands push expected
// writer requests and completions; a monitor pops and compares them.
module tb_bram_load_sequencer;

    localparam int ADDR_W = 9;
    localparam int CNT_W  = 12;
    localparam int TMO    = 16;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [CNT_W-1:0]  byte_count;
    logic              abort;
    logic              busy;
    logic              done;
    logic [1:0]        err_code;
    logic [ADDR_W:0]   words_done;
    logic              wr_enable;
    logic [ADDR_W-1:0] wr_addr;
    logic [3:0]        wr_bytes;
    logic              wr_complete;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int last_wren_cyc = 0;
    int prev_wren_cyc = 0;
    int wren_seen = 0;
    int wr_lat = 5;
    bit writer_on = 1'b1;
    int w_cnt = 0;

    logic [12:0] exp_req[$];
    logic [11:0] exp_done[$];

    bram_load_sequencer #(
        .ADDR_W         (ADDR_W),
        .CNT_W          (CNT_W),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .base_addr   (base_addr),
        .byte_count  (byte_count),
        .abort       (abort),
        .busy        (busy),
        .done        (done),
        .err_code    (err_code),
        .words_done  (words_done),
        .wr_enable   (wr_enable),
        .wr_addr     (wr_addr),
        .wr_bytes    (wr_bytes),
        .wr_complete (wr_complete)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Writer model: one completion pulse wr_lat cycles after each request.
    initial begin
        wr_complete = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            wr_complete = 1'b0;
            if (!rst_n) begin
                w_cnt = 0;
            end else if (w_cnt > 0) begin
                w_cnt--;
                if (w_cnt == 0) wr_complete = 1'b1;
            end
            if (rst_n && wr_enable && writer_on) w_cnt = wr_lat;
        end
    end

    // Monitor: compares every request and every completion against the queues.
    initial forever begin
        @(negedge clk);
        if (rst_n && wr_enable) begin
            logic [12:0] e;
            prev_wren_cyc = last_wren_cyc;
            last_wren_cyc = cyc;
            wren_seen++;
            if (exp_req.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_wr_enable: addr 0x%0h bytes %b with no request expected", wr_addr, wr_bytes);
            end else begin
                e = exp_req.pop_front();
                chk("wr_addr", 32'(wr_addr), 32'(e[12:4]));
                chk("wr_bytes", 32'(wr_bytes), 32'(e[3:0]));
            end
        end
        if (rst_n && done) begin
            logic [11:0] d;
            if (exp_done.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_done: err %0d words %0d with no completion expected", err_code, words_done);
            end else begin
                d = exp_done.pop_front();
                chk("done_err_code", 32'(err_code), 32'(d[11:10]));
                chk("done_words_done", 32'(words_done), 32'(d[9:0]));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push_req(input logic [8:0] a, input logic [3:0] b);
        exp_req.push_back({a, b});
    endtask

    task automatic push_done(input logic [1:0] e, input logic [9:0] w);
        exp_done.push_back({e, w});
    endtask

    // Drives a start strobe; checks that the first request follows one cycle later.
    task automatic issue(input logic [8:0] b, input logic [11:0] c, input logic ab);
        base_addr  = b;
        byte_count = c;
        start      = 1'b1;
        abort      = ab;
        tick();
        start = 1'b0;
        abort = 1'b0;
        @(negedge clk);
        chk("issue_wr_enable", 32'(wr_enable), (c != 12'd0) ? 32'd1 : 32'd0);
        chk("issue_busy", 32'(busy), 32'd1);
    endtask

    task automatic wait_done(input string name);
        int k;
        for (k = 0; k < 300; k++) begin
            if (done) break;
            @(negedge clk);
        end
        chk({name, "_done_seen"}, (k < 300) ? 32'd1 : 32'd0, 32'd1);
        tick();
    endtask

    initial begin
        rst_n      = 1'b0;
        start      = 1'b0;
        base_addr  = '0;
        byte_count = '0;
        abort      = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_wr_enable", 32'(wr_enable), 32'd0);
        chk("rst_err_code", 32'(err_code), 32'd0);
        chk("rst_words_done", 32'(words_done), 32'd0);
        chk("rst_wr_addr", 32'(wr_addr), 32'd0);
        chk("rst_wr_bytes", 32'(wr_bytes), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // 8 bytes from 0x010; a stray start during WAIT must be ignored.
        push_req(9'h010, 4'b1111);
        push_req(9'h011, 4'b1111);
        push_done(2'b00, 10'd2);
        issue(9'h010, 12'd8, 1'b0);
        tick();
        base_addr  = 9'h100;
        byte_count = 12'd4;
        start      = 1'b1;
        tick();
        start = 1'b0;
        wait_done("len8");
        chk("len8_issue_spacing", 32'(last_wren_cyc - prev_wren_cyc), 32'(wr_lat + 2));
        chk("len8_idle_busy", 32'(busy), 32'd0);

        // 6 bytes: partial tail word.
        push_req(9'h010, 4'b1111);
        push_req(9'h011, 4'b1100);
        push_done(2'b00, 10'd2);
        issue(9'h010, 12'd6, 1'b0);
        wait_done("len6");

        // 3 bytes with abort asserted alongside start: abort is dropped.
        push_req(9'h060, 4'b1110);
        push_done(2'b00, 10'd1);
        issue(9'h060, 12'd3, 1'b1);
        wait_done("len3");

        // Address wrap at the top of the BRAM.
        push_req(9'h1FF, 4'b1111);
        push_req(9'h000, 4'b1111);
        push_done(2'b00, 10'd2);
        issue(9'h1FF, 12'd8, 1'b0);
        wait_done("wrap");

        // Zero-length command: one busy cycle carrying done, no request.
        push_done(2'b00, 10'd0);
        issue(9'h070, 12'd0, 1'b0);
        chk("zero_done", 32'(done), 32'd1);
        @(negedge clk);
        chk("zero_busy_after", 32'(busy), 32'd0);
        chk("zero_done_after", 32'(done), 32'd0);
        tick();

        // Timeout: writer silent; done arrives TMO cycles after WAIT is entered.
        writer_on = 1'b0;
        push_req(9'h050, 4'b1111);
        push_done(2'b01, 10'd0);
        issue(9'h050, 12'd4, 1'b0);
        begin
            int k;
            for (k = 0; k < 100; k++) begin
                if (done) break;
                @(negedge clk);
            end
            chk("timeout_cycles_after_issue", 32'(k), 32'(TMO + 1));
        end
        tick();
        chk("timeout_err_held", 32'(err_code), 32'd1);
        writer_on = 1'b1;

        // Completion on the very cycle the timeout expires wins.
        wr_lat = TMO;
        push_req(9'h080, 4'b1111);
        push_done(2'b00, 10'd1);
        issue(9'h080, 12'd4, 1'b0);
        wait_done("cmpl_at_limit");

        // One cycle later than the limit times out.
        wr_lat = TMO + 1;
        push_req(9'h081, 4'b1111);
        push_done(2'b01, 10'd0);
        issue(9'h081, 12'd4, 1'b0);
        wait_done("cmpl_past_limit");
        repeat (3) tick();
        wr_lat = 5;

        // Abort during the second word's WAIT: exactly two words written.
        push_req(9'h040, 4'b1111);
        push_req(9'h041, 4'b1111);
        push_done(2'b10, 10'd2);
        begin
            int seen0;
            int k;
            seen0 = wren_seen;
            issue(9'h040, 12'd16, 1'b0);
            for (k = 0; k < 100; k++) begin
                if (wren_seen - seen0 >= 2) break;
                @(negedge clk);
            end
            chk("abort_second_word_seen", (k < 100) ? 32'd1 : 32'd0, 32'd1);
        end
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        wait_done("abort");
        repeat (2) tick();
        chk("abort_err_held", 32'(err_code), 32'd2);

        // Reset mid-WAIT, then an immediate fresh command.
        push_req(9'h020, 4'b1111);
        issue(9'h020, 12'd8, 1'b0);
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_wr_enable", 32'(wr_enable), 32'd0);
        chk("midrst_err_code", 32'(err_code), 32'd0);
        chk("midrst_words_done", 32'(words_done), 32'd0);
        chk("midrst_wr_addr", 32'(wr_addr), 32'd0);
        chk("midrst_wr_bytes", 32'(wr_bytes), 32'd0);
        tick();
        rst_n = 1'b1;
        push_req(9'h030, 4'b1111);
        push_done(2'b00, 10'd1);
        issue(9'h030, 12'd4, 1'b0);
        wait_done("post_reset");

        repeat (3) tick();
        chk("req_queue_drained", 32'(exp_req.size()), 32'd0);
        chk("done_queue_drained", 32'(exp_done.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, %0d checks %0d errors so far", n_checks, n_errors);
        $fatal(1, "watchdog expired");
    end

endmodule
